// File: rtl/pilot_insert.sv
// pilot_insert: buffers the 48 data symbols of one OFDM symbol in a ping-pong
// bank and emits a 64-bin IFFT frame in natural bin order, with 4 BPSK pilots
// (127-periodic polarity) and 12 null bins. Samples are 1.1.14 signed.
module pilot_insert #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] PILOT_AMP = 16'h4000
) (
  input  logic             pilot_clk,
  input  logic             pilot_rst_n,
  input  logic             din_valid,
  input  logic [5:0]       din_index,
  input  logic [WIDTH-1:0] din_real,
  input  logic [WIDTH-1:0] din_imag,
  output logic             dout_valid,
  output logic             dout_sop,
  output logic [5:0]       dout_index,
  output logic [WIDTH-1:0] dout_real,
  output logic [WIDTH-1:0] dout_imag,
  output logic             ovf_err
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's complement negation that saturates the single unrepresentable case.
  function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] x);
    if (x == S_MIN) return S_MAX;
    return -x;
  endfunction

  logic [2*WIDTH-1:0] bank [2][48];
  logic               wr_bank, rd_bank, last47;
  state_t             state, state_nxt;
  logic [5:0]         rd_cnt_p0;
  logic [6:0]         lfsr;

  logic               din_is47, commit, commit_idle, wr_sel, rd_vld_p0;
  logic               is_data, is_pilot, pilot_inv, pol;
  logic [5:0]         bin_d;
  logic [2*WIDTH-1:0] rd_word;
  logic signed [WIDTH-1:0] pilot_val;

  logic             vld_p1, sop_p1;
  logic [5:0]       idx_p1;
  logic [WIDTH-1:0] re_p1, im_p1;

  assign din_is47    = din_valid && (din_index == 6'd47);
  assign commit      = last47 && !din_is47;
  assign commit_idle = commit && (state == IDLE);
  // The sample arriving in the commit cycle already belongs to the next symbol.
  assign wr_sel      = commit_idle ? ~wr_bank : wr_bank;
  assign rd_vld_p0   = (state == READ);

  // FSM state register
  always_ff @(posedge pilot_clk or negedge pilot_rst_n) begin
    if (!pilot_rst_n) state <= IDLE;
    else              state <= state_nxt;
  end

  // FSM next state: a committed symbol starts readout; bin 63 ends it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit) state_nxt = READ;
      READ:    if (rd_cnt_p0 == 6'd63) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bank select, end-of-symbol detect and sticky overflow flag
  always_ff @(posedge pilot_clk or negedge pilot_rst_n) begin
    if (!pilot_rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      last47  <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      last47 <= din_is47;
      if (commit) begin
        if (state == IDLE) begin
          rd_bank <= wr_bank;
          wr_bank <= ~wr_bank;
        end else begin
          ovf_err <= 1'b1;
        end
      end
    end
  end

  // Ping-pong sample store; out-of-range indices are discarded
  always_ff @(posedge pilot_clk or negedge pilot_rst_n) begin
    if (!pilot_rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < 48; k++)
          bank[b][k] <= '0;
    end else if (din_valid && (din_index <= 6'd47)) begin
      bank[wr_sel][din_index] <= {din_real, din_imag};
    end
  end

  // Readout bin counter
  always_ff @(posedge pilot_clk or negedge pilot_rst_n) begin
    if (!pilot_rst_n)      rd_cnt_p0 <= 6'd0;
    else if (rd_vld_p0)    rd_cnt_p0 <= rd_cnt_p0 + 6'd1;
    else                   rd_cnt_p0 <= 6'd0;
  end

  // Pilot polarity sequence, stepped once per completed frame
  always_ff @(posedge pilot_clk or negedge pilot_rst_n) begin
    if (!pilot_rst_n)
      lfsr <= 7'b1111111;
    else if (rd_vld_p0 && (rd_cnt_p0 == 6'd63))
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
  end

  // Bin map: bin number -> data slot, pilot or null
  always_comb begin
    is_data   = 1'b0;
    is_pilot  = 1'b0;
    pilot_inv = 1'b0;
    bin_d     = 6'd0;
    if (rd_cnt_p0 >= 6'd1 && rd_cnt_p0 <= 6'd6) begin
      is_data = 1'b1; bin_d = rd_cnt_p0 + 6'd23;
    end else if (rd_cnt_p0 == 6'd7 || rd_cnt_p0 == 6'd43 || rd_cnt_p0 == 6'd57) begin
      is_pilot = 1'b1;
    end else if (rd_cnt_p0 >= 6'd8 && rd_cnt_p0 <= 6'd20) begin
      is_data = 1'b1; bin_d = rd_cnt_p0 + 6'd22;
    end else if (rd_cnt_p0 == 6'd21) begin
      is_pilot = 1'b1; pilot_inv = 1'b1;
    end else if (rd_cnt_p0 >= 6'd22 && rd_cnt_p0 <= 6'd26) begin
      is_data = 1'b1; bin_d = rd_cnt_p0 + 6'd21;
    end else if (rd_cnt_p0 >= 6'd38 && rd_cnt_p0 <= 6'd42) begin
      is_data = 1'b1; bin_d = rd_cnt_p0 - 6'd38;
    end else if (rd_cnt_p0 >= 6'd44 && rd_cnt_p0 <= 6'd56) begin
      is_data = 1'b1; bin_d = rd_cnt_p0 - 6'd39;
    end else if (rd_cnt_p0 >= 6'd58) begin
      is_data = 1'b1; bin_d = rd_cnt_p0 - 6'd40;
    end
  end

  assign rd_word   = bank[rd_bank][bin_d];
  assign pol       = lfsr[6] ^ lfsr[3];
  assign pilot_val = (pol ^ pilot_inv) ? neg_sat(PILOT_AMP) : PILOT_AMP;

  // ---- stage p0 -> p1: registered output bin ----
  // Output register; forced to zero outside readout
  always_ff @(posedge pilot_clk or negedge pilot_rst_n) begin
    if (!pilot_rst_n || !rd_vld_p0) begin
      vld_p1 <= 1'b0;
      sop_p1 <= 1'b0;
      idx_p1 <= 6'd0;
      re_p1  <= '0;
      im_p1  <= '0;
    end else begin
      vld_p1 <= 1'b1;
      sop_p1 <= (rd_cnt_p0 == 6'd0);
      idx_p1 <= rd_cnt_p0;
      re_p1  <= is_data ? rd_word[2*WIDTH-1:WIDTH] : (is_pilot ? pilot_val : '0);
      im_p1  <= is_data ? rd_word[WIDTH-1:0] : '0;
    end
  end

  assign dout_valid = vld_p1;
  assign dout_sop   = sop_p1;
  assign dout_index = idx_p1;
  assign dout_real  = re_p1;
  assign dout_imag  = im_p1;

endmodule

// File: tb/tb_pilot_insert.sv
// Testbench for pilot_insert: directed symbols, table of hand-computed bins,
// pilot polarity sequence, reset abort, overflow drop and ignored indices.
module tb_pilot_insert;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid;
  logic [5:0]  din_index;
  logic [15:0] din_real, din_imag;
  logic        dout_valid, dout_sop, ovf_err;
  logic [5:0]  dout_index;
  logic [15:0] dout_real, dout_imag;

  always #5 clk = ~clk;

  pilot_insert #(.WIDTH(16), .PILOT_AMP(16'h4000)) dut (
    .pilot_clk(clk), .pilot_rst_n(rst_n),
    .din_valid(din_valid), .din_index(din_index), .din_real(din_real), .din_imag(din_imag),
    .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_index(dout_index),
    .dout_real(dout_real), .dout_imag(dout_imag), .ovf_err(ovf_err)
  );

  typedef struct {
    int          bin;
    logic [15:0] r;
    logic [15:0] i;
  } vec_t;

  vec_t tv[20];
  logic [15:0] p7_tbl[8];
  bit          pol_tbl[8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drv_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame capture
  logic [15:0] cap_r[64], cap_i[64];
  int vld_run = 0, last_run = 0, frames_done = 0, sop_cyc = 0, last_vld_cyc = 0, valid_cycles = 0;
  bit seq_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      vld_run = 0;
    end else if (dout_valid) begin
      if (vld_run == 0) seq_bad = 0;
      if (dout_index != 6'(vld_run) || dout_sop != (vld_run == 0)) seq_bad = 1;
      if (dout_sop) sop_cyc = cyc;
      cap_r[dout_index] = dout_real;
      cap_i[dout_index] = dout_imag;
      last_vld_cyc = cyc;
      vld_run++;
      valid_cycles++;
    end else if (vld_run > 0) begin
      last_run = vld_run;
      vld_run = 0;
      frames_done++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int idx, input logic [15:0] r, input logic [15:0] i);
    din_valid = v;
    din_index = 6'(idx);
    din_real  = r;
    din_imag  = i;
    drv_cyc   = cyc;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] smp_r(input int k, input int tag);
    return 16'((k << 8) | tag);
  endfunction

  function automatic logic [15:0] smp_i(input int k, input int tag);
    return 16'(-((k << 8) | tag));
  endfunction

  // Sends data 0..47 (each held 'hold' cycles, then 'gap' idle cycles), then one idle cycle.
  task automatic send_symbol(input int hold, input int gap, input int tag, input bit inject50,
                             output int commit);
    commit = -1;
    for (int k = 0; k < 48; k++) begin
      if (inject50 && k == 47) begin
        drive(1'b1, 50, 16'h7FFF, 16'h8001);
        drive(1'b1, 50, 16'h7FFF, 16'h8001);
      end
      for (int h = 0; h < hold; h++) drive(1'b1, k, smp_r(k, tag), smp_i(k, tag));
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 0, 16'h0, 16'h0);
        if (k == 47 && g == 0) commit = drv_cyc;
      end
    end
    drive(1'b0, 0, 16'h0, 16'h0);
    if (gap == 0) commit = drv_cyc;
  endtask

  task automatic wait_frame(input int target);
    int n = 0;
    while (frames_done < target && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL frame_timeout: frames %0d required %0d", frames_done, target);
    end
  endtask

  // Expected frame derived by walking subcarriers -26..26 in order.
  logic [15:0] exp_r[64], exp_i[64];
  task automatic model_frame(input int tag, input bit pol);
    int d = 0;
    int b;
    for (int j = 0; j < 64; j++) begin exp_r[j] = 16'h0; exp_i[j] = 16'h0; end
    for (int s = -26; s <= 26; s++) begin
      if (s == 0) continue;
      b = (s + 64) % 64;
      if (s == -21 || s == -7 || s == 7) begin
        exp_r[b] = pol ? 16'hC000 : 16'h4000;
      end else if (s == 21) begin
        exp_r[b] = pol ? 16'h4000 : 16'hC000;
      end else begin
        exp_r[b] = smp_r(d, tag);
        exp_i[b] = smp_i(d, tag);
        d++;
      end
    end
  endtask

  task automatic check_frame(input string name, input int tag, input bit pol, input int commit);
    int bad = 0;
    int first = 0;
    model_frame(tag, pol);
    for (int b = 63; b >= 0; b--)
      if (cap_r[b] !== exp_r[b] || cap_i[b] !== exp_i[b]) begin bad++; first = b; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_bins: %0d wrong, bin %0d actual %h/%h required %h/%h",
               name, bad, first, cap_r[first], cap_i[first], exp_r[first], exp_i[first]);
    end
    chk({name, "_len"}, last_run, 64);
    chk({name, "_sop_latency"}, sop_cyc - commit, 2);
    chk({name, "_last_latency"}, last_vld_cyc - commit, 65);
    chk({name, "_order"}, 32'(seq_bad), 0);
  endtask

  initial begin
    int cm, ca, cb, vc, fd, n;
    din_valid = 1'b0; din_index = 6'd0; din_real = 16'h0; din_imag = 16'h0;

    tv[0]  = '{38, 16'h0000, 16'h0000}; tv[1]  = '{39, 16'h0100, 16'hFF00};
    tv[2]  = '{42, 16'h0400, 16'hFC00}; tv[3]  = '{43, 16'h4000, 16'h0000};
    tv[4]  = '{44, 16'h0500, 16'hFB00}; tv[5]  = '{56, 16'h1100, 16'hEF00};
    tv[6]  = '{57, 16'h4000, 16'h0000}; tv[7]  = '{58, 16'h1200, 16'hEE00};
    tv[8]  = '{63, 16'h1700, 16'hE900}; tv[9]  = '{0,  16'h0000, 16'h0000};
    tv[10] = '{1,  16'h1800, 16'hE800}; tv[11] = '{6,  16'h1D00, 16'hE300};
    tv[12] = '{7,  16'h4000, 16'h0000}; tv[13] = '{8,  16'h1E00, 16'hE200};
    tv[14] = '{20, 16'h2A00, 16'hD600}; tv[15] = '{21, 16'hC000, 16'h0000};
    tv[16] = '{22, 16'h2B00, 16'hD500}; tv[17] = '{26, 16'h2F00, 16'hD100};
    tv[18] = '{27, 16'h0000, 16'h0000}; tv[19] = '{37, 16'h0000, 16'h0000};

    p7_tbl[0] = 16'h4000; p7_tbl[1] = 16'h4000; p7_tbl[2] = 16'h4000; p7_tbl[3] = 16'h4000;
    p7_tbl[4] = 16'hC000; p7_tbl[5] = 16'hC000; p7_tbl[6] = 16'hC000; p7_tbl[7] = 16'h4000;
    pol_tbl[0] = 0; pol_tbl[1] = 0; pol_tbl[2] = 0; pol_tbl[3] = 0;
    pol_tbl[4] = 1; pol_tbl[5] = 1; pol_tbl[6] = 1; pol_tbl[7] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", dout_valid, 0);
    chk("rst_sop", dout_sop, 0);
    chk("rst_index", dout_index, 0);
    chk("rst_real", dout_real, 0);
    chk("rst_imag", dout_imag, 0);
    chk("rst_ovf", ovf_err, 0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Mapper pattern, 4 cycles per sample, then pilot polarity over 8 frames
    send_symbol(4, 0, 0, 1'b0, cm);
    wait_frame(1);
    check_frame("t2", 0, 1'b0, cm);
    for (int j = 0; j < 20; j++) begin
      chk($sformatf("t2_bin%0d_re", tv[j].bin), cap_r[tv[j].bin], tv[j].r);
      chk($sformatf("t2_bin%0d_im", tv[j].bin), cap_i[tv[j].bin], tv[j].i);
    end
    chk("t2_ovf", ovf_err, 0);

    for (int f = 0; f < 8; f++) begin
      if (f > 0) begin
        send_symbol(1, 0, f, 1'b0, cm);
        wait_frame(f + 1);
        check_frame($sformatf("t3_f%0d", f), f, pol_tbl[f], cm);
      end
      chk($sformatf("t3_f%0d_bin7", f), cap_r[7], p7_tbl[f]);
      chk($sformatf("t3_f%0d_bin21", f), cap_r[21], 16'(-p7_tbl[f]));
    end

    // Reset in the middle of a frame
    send_symbol(1, 0, 8, 1'b0, cm);
    n = 0;
    while (!dout_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("t1_started", dout_valid, 1);
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("t1_valid", dout_valid, 0);
    chk("t1_sop", dout_sop, 0);
    chk("t1_index", dout_index, 0);
    chk("t1_real", dout_real, 0);
    chk("t1_imag", dout_imag, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_frames", frames_done, 8);
    chk("t1_after_valid", dout_valid, 0);

    // Single-cycle strobes; first frame after reset has polarity +1
    send_symbol(1, 3, 9, 1'b0, cm);
    wait_frame(9);
    check_frame("t6", 9, 1'b0, cm);
    chk("t1_pol_bin7", cap_r[7], 16'h4000);

    // Ignored index
    vc = valid_cycles;
    fd = frames_done;
    for (int j = 0; j < 6; j++) drive(1'b1, 50, 16'h7FFF, 16'h8001);
    drive(1'b0, 0, 16'h0, 16'h0);
    repeat (80) begin @(posedge clk); #1; end
    chk("t5_no_output", valid_cycles, vc);
    chk("t5_no_frame", frames_done, fd);
    send_symbol(1, 0, 10, 1'b1, cm);
    wait_frame(10);
    check_frame("t5", 10, 1'b0, cm);

    // Back-to-back symbols: the second is dropped
    send_symbol(1, 0, 32, 1'b0, ca);
    send_symbol(1, 0, 33, 1'b0, cb);
    wait_frame(11);
    check_frame("t4_a", 32, 1'b0, ca);
    chk("t4_ovf", ovf_err, 1);
    vc = valid_cycles;
    repeat (80) begin @(posedge clk); #1; end
    chk("t4_dropped", valid_cycles, vc);
    send_symbol(1, 0, 34, 1'b0, cm);
    wait_frame(12);
    check_frame("t4_c", 34, 1'b0, cm);
    chk("t4_ovf_sticky", ovf_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
